// File: rtl/spu_sm_pkg.sv
// Shared encodings for the softmax sequencer: datapath mode codes,
// controller FSM states and the phase tag carried down the delay lines.
package spu_sm_pkg;

  localparam logic [2:0] SM_IDLE       = 3'b000;
  localparam logic [2:0] SM_EU_STAGE_A = 3'b001;
  localparam logic [2:0] SM_RECI       = 3'b011;
  localparam logic [2:0] SM_EU_STAGE_B = 3'b100;
  localparam logic [2:0] SM_MAX        = 3'b101;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_MAX_RD    = 4'd1,
    ST_MAX_DRN   = 4'd2,
    ST_EUA_RD    = 4'd3,
    ST_EUA_DRN   = 4'd4,
    ST_RECI_REQ  = 4'd5,
    ST_RECI_WAIT = 4'd6,
    ST_EUB_RD    = 4'd7,
    ST_EUB_DRN   = 4'd8,
    ST_DONE      = 4'd9
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_MAX  = 2'd1,
    PH_EUA  = 2'd2,
    PH_EUB  = 2'd3
  } phase_e;

endpackage

// File: rtl/spu_sm_ctrl_dly.sv
// Fixed-latency shift register aligning {valid, phase, index} with the
// buffer / exp-unit pipelines; DEPTH 0 degenerates to a wire.
module spu_sm_ctrl_dly #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         core_clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr [DEPTH];

      // shift stage by stage; reset flushes in-flight entries
      always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/spu_sm_ctrl.sv
// Softmax sequencer: walks one token row through MAX, exp-sum, reciprocal
// and normalise phases, issuing buffer addresses and aligned datapath enables.
module spu_sm_ctrl
  import spu_sm_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int RD_LAT  = 1,
  parameter int EXP_LAT = 1
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   token_len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        sm_state,
  output logic              comp_rst,
  output logic              comp_en,
  output logic              adder_tree_en,
  output logic              reci_exp_sum_en,
  input  logic              reci_exp_sum_finish
);

  localparam int DRN_SUM = RD_LAT + EXP_LAT;
  localparam int DRN_W   = (DRN_SUM < 1) ? 1 : $clog2(DRN_SUM + 1);
  localparam logic [DRN_W-1:0] MAX_DRN_N = DRN_W'(RD_LAT);
  localparam logic [DRN_W-1:0] EU_DRN_N  = DRN_W'(DRN_SUM);

  ctrl_state_e       state;
  phase_e            phase_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W-1:0] rd_base_r;
  logic [ADDR_W-1:0] wr_base_r;
  logic [ADDR_W-1:0] idx_r;
  logic [DRN_W-1:0]  drn_cnt;
  logic              zero_r;

  logic [ADDR_W-1:0] nxt_idx;
  logic              rd_last;

  assign nxt_idx = word_cnt[ADDR_W-1:0];
  assign rd_last = (word_cnt == len_r);

  // controller FSM; outputs are registered for the state being entered
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      phase_r         <= PH_NONE;
      len_r           <= '0;
      word_cnt        <= '0;
      rd_base_r       <= '0;
      wr_base_r       <= '0;
      idx_r           <= '0;
      drn_cnt         <= '0;
      zero_r          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      sm_state        <= SM_IDLE;
      comp_rst        <= 1'b0;
      reci_exp_sum_en <= 1'b0;
    end else begin
      done            <= 1'b0;
      comp_rst        <= 1'b0;
      reci_exp_sum_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_r     <= token_len;
            rd_base_r <= rd_base;
            wr_base_r <= wr_base;
            busy      <= 1'b1;
            if (token_len == '0) begin
              state  <= ST_DONE;
              zero_r <= 1'b1;
            end else begin
              state    <= ST_MAX_RD;
              sm_state <= SM_MAX;
              phase_r  <= PH_MAX;
              rd_en    <= 1'b1;
              rd_addr  <= rd_base;
              idx_r    <= '0;
              word_cnt <= {{ADDR_W{1'b0}}, 1'b1};
              comp_rst <= 1'b1;
            end
          end
        end
        ST_MAX_RD, ST_EUA_RD, ST_EUB_RD: begin
          if (!rd_last) begin
            rd_en    <= 1'b1;
            rd_addr  <= rd_base_r + nxt_idx;
            idx_r    <= nxt_idx;
            word_cnt <= word_cnt + 1'b1;
          end else begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            drn_cnt <= {{(DRN_W-1){1'b0}}, 1'b1};
            if (state == ST_MAX_RD) begin
              if (RD_LAT == 0) begin
                state    <= ST_EUA_RD;
                sm_state <= SM_EU_STAGE_A;
                phase_r  <= PH_EUA;
                rd_en    <= 1'b1;
                rd_addr  <= rd_base_r;
                idx_r    <= '0;
                word_cnt <= {{ADDR_W{1'b0}}, 1'b1};
              end else begin
                state <= ST_MAX_DRN;
              end
            end else if (state == ST_EUA_RD) begin
              if (DRN_SUM == 0) begin
                state           <= ST_RECI_REQ;
                sm_state        <= SM_RECI;
                reci_exp_sum_en <= 1'b1;
              end else begin
                state <= ST_EUA_DRN;
              end
            end else begin
              if (DRN_SUM == 0) begin
                state    <= ST_DONE;
                sm_state <= SM_IDLE;
                done     <= 1'b1;
              end else begin
                state <= ST_EUB_DRN;
              end
            end
          end
        end
        ST_MAX_DRN: begin
          if (drn_cnt >= MAX_DRN_N) begin
            state    <= ST_EUA_RD;
            sm_state <= SM_EU_STAGE_A;
            phase_r  <= PH_EUA;
            rd_en    <= 1'b1;
            rd_addr  <= rd_base_r;
            idx_r    <= '0;
            word_cnt <= {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        ST_EUA_DRN: begin
          if (drn_cnt >= EU_DRN_N) begin
            state           <= ST_RECI_REQ;
            sm_state        <= SM_RECI;
            reci_exp_sum_en <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        // divider may finish in the request cycle itself; no timeout while waiting
        ST_RECI_REQ, ST_RECI_WAIT: begin
          if (reci_exp_sum_finish) begin
            state    <= ST_EUB_RD;
            sm_state <= SM_EU_STAGE_B;
            phase_r  <= PH_EUB;
            rd_en    <= 1'b1;
            rd_addr  <= rd_base_r;
            idx_r    <= '0;
            word_cnt <= {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            state <= ST_RECI_WAIT;
          end
        end
        ST_EUB_DRN: begin
          if (drn_cnt >= EU_DRN_N) begin
            state    <= ST_DONE;
            sm_state <= SM_IDLE;
            done     <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        // a zero-length row spends one extra cycle here before pulsing done
        ST_DONE: begin
          if (zero_r) begin
            zero_r <= 1'b0;
            done   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          rd_en    <= 1'b0;
          rd_addr  <= '0;
          sm_state <= SM_IDLE;
        end
      endcase
    end
  end

  logic [2:0]        d1_in, d1_out;
  logic [ADDR_W+2:0] d2_in, d2_out;
  logic [ADDR_W-1:0] d2_idx;

  assign d1_in = {rd_en, phase_r};
  assign d2_in = {rd_en, phase_r, idx_r};

  spu_sm_ctrl_dly #(.DEPTH(RD_LAT), .W(3)) u_dly_rd (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .din      (d1_in),
    .dout     (d1_out)
  );

  spu_sm_ctrl_dly #(.DEPTH(DRN_SUM), .W(ADDR_W + 3)) u_dly_exp (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .din      (d2_in),
    .dout     (d2_out)
  );

  // enables only fire for the phase that issued the read
  assign d2_idx        = d2_out[ADDR_W-1:0];
  assign comp_en       = d1_out[2] && (d1_out[1:0] == PH_MAX);
  assign adder_tree_en = d2_out[ADDR_W+2] && (d2_out[ADDR_W+1:ADDR_W] == PH_EUA);
  assign wr_en         = d2_out[ADDR_W+2] && (d2_out[ADDR_W+1:ADDR_W] == PH_EUB);
  assign wr_addr       = wr_en ? (wr_base_r + d2_idx) : '0;

endmodule

// File: doc/spu_sm_ctrl.md
Name: spu_sm_ctrl

Overview:
Sequencer that drives the softmax datapath block in the SPU and moves one token's row through it. On `start` it runs four phases in order, each one a full pass over the row or a handshake:
- MAX: max search.
- EU_STAGE_A: exp-sum accumulation.
- RECI: divider handshake.
- EU_STAGE_B: normalise and write back.

It generates buffer read/write addresses and strobes, and aligns the datapath enables to the buffer and exp-unit pipeline latencies. It sits between the SPU top-level scheduler and the softmax datapath plus its scratch buffer.

Parameters:
- ADDR_W, 9: buffer word-address width; one word is 4 packed int8.
- RD_LAT, 1: cycles from `rd_en` to read data valid at the datapath input.
- EXP_LAT, 1: cycles from datapath input to exp-unit output valid.

Ports:
- core_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- token_len  in  ADDR_W+1  row length in words, 0..2^ADDR_W; sampled with `start`
- rd_base  in  ADDR_W  first read word address; sampled with `start`
- wr_base  in  ADDR_W  first write word address; sampled with `start`
- busy  out  1  high from the cycle after `start` is accepted until DONE inclusive
- done  out  1  one-cycle completion pulse
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- wr_en  out  1  buffer write strobe for the datapath's packed output word
- wr_addr  out  ADDR_W  buffer write address
- sm_state  out  3  datapath mode
- comp_rst  out  1  max-register clear
- comp_en  out  1  max-compare enable
- adder_tree_en  out  1  exp-sum accumulate enable
- reci_exp_sum_en  out  1  divider start pulse
- reci_exp_sum_finish  in  1  divider completion

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately with no `done`; in-flight delay-line entries are cleared.
- FSM states: IDLE, MAX_RD, MAX_DRN, EUA_RD, EUA_DRN, RECI_REQ, RECI_WAIT, EUB_RD, EUB_DRN, DONE.
- `sm_state` mapping:
  - MAX (3'b101) in MAX_*.
  - EU_STAGE_A (3'b001) in EUA_*.
  - RECI (3'b011) in RECI_*.
  - EU_STAGE_B (3'b100) in EUB_*.
  - IDLE (3'b000) in IDLE and DONE.
- IDLE:
  - `start` with `token_len`≠0 latches the inputs and goes to MAX_RD.
  - `token_len`=0 goes straight to DONE; no reads, writes or datapath enables are issued.
- `start` while busy is ignored and not queued.
- *_RD states:
  - `rd_en`=1 for exactly `token_len` consecutive cycles.
  - `rd_addr` = rd_base+i, i=0..len-1, mod 2^ADDR_W; addresses wrap with no error.
  - The word index advances every cycle; there is no stall.
- MAX_RD: `comp_rst`=1 in its first cycle only.
- `comp_en`: the MAX-phase `rd_en` delayed RD_LAT cycles. It never overlaps `comp_rst` when RD_LAT≥1.
- MAX_DRN: lasts RD_LAT cycles.
- `adder_tree_en`: the EUA-phase `rd_en` delayed RD_LAT+EXP_LAT cycles.
- EUA_DRN: lasts RD_LAT+EXP_LAT cycles.
- RECI_REQ:
  - Lasts one cycle with `reci_exp_sum_en`=1.
  - A `reci_exp_sum_finish` seen in RECI_REQ or RECI_WAIT moves the FSM to EUB_RD next cycle.
  - RECI_WAIT has no timeout.
- `wr_en`: the EUB-phase `rd_en` delayed RD_LAT+EXP_LAT cycles.
- `wr_addr` = wr_base+i, delayed with the same index. It is 0 whenever `wr_en`=0.
- EUB_DRN: lasts RD_LAT+EXP_LAT cycles.
- DONE: `done`=1 for one cycle, then IDLE. `busy` falls with the exit from DONE.
- Delayed enables are pure shifted copies gated by the phase that issued the read, so no enable leaks across a phase boundary.
- Counters:
  - Word counter is ADDR_W+1 bits.
  - Drain counter is ceil(log2(RD_LAT+EXP_LAT+1)) bits.
- `rd_addr` is 0 when `rd_en`=0.

Decomposition:
- Package `spu_sm_pkg`:
  - sm_state localparams: IDLE, EU_STAGE_A, RECI, EU_STAGE_B, MAX.
  - Controller FSM state encodings.
- One sub-module, `spu_sm_ctrl_dly`:
  - Parameterised depth (0 allowed = wire) and width.
  - Async-reset shift register carrying {valid, phase, index}.
  - Two instances: depth RD_LAT and depth RD_LAT+EXP_LAT.

Test Plan:
- Nominal run:
  - Stimulus: RD_LAT=1, EXP_LAT=1, `token_len`=4, `rd_base`=0x10, `wr_base`=0x40, `start` sampled at t0; `reci_exp_sum_finish` asserted at t0+15.
  - Required, reads and enables: `rd_en` at t0+1..4, 6..9 and 16..19 with `rd_addr` 0x10..0x13; `comp_rst` at t0+1; `comp_en` at t0+2..5; `adder_tree_en` at t0+8..11; `reci_exp_sum_en` at t0+12.
  - Required, writes and completion: `wr_en` at t0+18..21 with `wr_addr` 0x40..0x43; `done` at t0+22; `busy` at t0+1..22.
- Wrap-around: `rd_base`=0x1FE, `token_len`=4 -> `rd_addr` 0x1FE, 0x1FF, 0x000, 0x001 in each phase; same wrap on `wr_addr`.
- Zero length: `token_len`=0 -> `done` at t0+2; `rd_en`, `wr_en` and all datapath enables stay 0; `sm_state` stays 0.
- Max length and blocked start: `token_len`=512 -> exactly 512 `rd_en` per phase, 512 `wr_en` in total; `start` pulsed mid-run is ignored.
- Divider handshake: `reci_exp_sum_finish` delayed 50 cycles -> FSM holds RECI_WAIT with `sm_state`=3'b011 and `rd_en`=0 throughout; `reci_exp_sum_finish` asserted in the RECI_REQ cycle itself -> EUB_RD follows the next cycle.
- Reset mid-run: `rst_n` low during EUA_RD -> all outputs 0 asynchronously; no `done`; a new `start` after release runs the full sequence cleanly.
